// File: rtl/coord_display.sv
// coord_display: debounced X/Y coordinate viewer on an 8-digit multiplexed seven-segment display
//   Clk, Reset (sync, active-high); xCoord/yCoord: coordinate inputs; Freeze: hold displayed pair
//   an/seg/dp: active-low digit enables, segments (g..a) and decimal point
//   UpdateCount: display loads (wrapping); Valid: displayed pair equals the stable input pair
module coord_display #(
  parameter int STABLE_CYCLES = 4,
  parameter int REFRESH_DIV = 100000
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [31:0] xCoord,
  input  logic [31:0] yCoord,
  input  logic        Freeze,
  output logic [7:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [15:0] UpdateCount,
  output logic        Valid
);
  localparam int SW = $clog2(STABLE_CYCLES);
  localparam int PW = $clog2(REFRESH_DIV);
  localparam logic [SW-1:0] SMAX = SW'(STABLE_CYCLES - 1);
  localparam logic [PW-1:0] PMAX = PW'(REFRESH_DIV - 1);
  logic [31:0] candX, candY, dispX, dispY, candXN, candYN, dispXN, dispYN;
  logic [SW-1:0] stab, stabN;
  logic [PW-1:0] presc;
  logic [2:0] idx, idxN;
  logic [4:0] sh;
  logic [3:0] nib;
  logic [6:0] segN;
  logic match, load, tick, loaded, dpN;
  always_comb begin
    match = {xCoord, yCoord} == {candX, candY};
    candXN = match ? candX : xCoord;
    candYN = match ? candY : yCoord;
    stabN = !match ? '0 : (stab < SMAX ? stab + 1'b1 : stab);
    load = match && stab == SMAX && !Freeze && {candX, candY} != {dispX, dispY};
    dispXN = load ? candX : dispX;
    dispYN = load ? candY : dispY;
    tick = presc == PMAX;
    idxN = tick ? idx + 3'd1 : idx;
    sh = {1'b0, idxN[1:0], 2'b00};
    // upper four digits show X, lower four show Y, most significant nibble leftmost
    nib = idxN[2] ? dispX[sh +: 4] : dispY[sh +: 4];
    // dp marks the X/Y separator and flags coordinates that do not fit in 16 bits
    dpN = !(idxN == 3'd4 || (idxN == 3'd7 && |dispX[31:16]) || (idxN == 3'd3 && |dispY[31:16]));
    segN = 7'b1111111;
    case (nib)
      4'h0: segN = 7'b1000000;
      4'h1: segN = 7'b1111001;
      4'h2: segN = 7'b0100100;
      4'h3: segN = 7'b0110000;
      4'h4: segN = 7'b0011001;
      4'h5: segN = 7'b0010010;
      4'h6: segN = 7'b0000010;
      4'h7: segN = 7'b1111000;
      4'h8: segN = 7'b0000000;
      4'h9: segN = 7'b0010000;
      4'hA: segN = 7'b0001000;
      4'hB: segN = 7'b0000011;
      4'hC: segN = 7'b1000110;
      4'hD: segN = 7'b0100001;
      4'hE: segN = 7'b0000110;
      4'hF: segN = 7'b0001110;
      default: segN = 7'b1111111;
    endcase
  end
  always_ff @(posedge Clk) begin
    if (Reset) begin
      candX <= '0;
      candY <= '0;
      dispX <= '0;
      dispY <= '0;
      stab <= '0;
      presc <= '0;
      idx <= '0;
      UpdateCount <= '0;
      Valid <= 1'b0;
      loaded <= 1'b0;
      an <= 8'hFE;
      seg <= 7'b1000000;
      dp <= 1'b1;
    end else begin
      candX <= candXN;
      candY <= candYN;
      stab <= stabN;
      dispX <= dispXN;
      dispY <= dispYN;
      UpdateCount <= UpdateCount + 16'(load);
      Valid <= stabN == SMAX && {candXN, candYN} == {dispXN, dispYN};
      loaded <= load;
      presc <= tick ? '0 : presc + 1'b1;
      idx <= idxN;
      if (tick) an <= ~(8'd1 << idxN);
      // a load refreshes the current digit one edge later, once dispX/dispY hold the new pair
      if (tick || loaded) begin
        seg <= segN;
        dp <= dpN;
      end
    end
  end
endmodule

// File: tb/tb_coord_display.sv
// tb_coord_display: randomized and directed checks of coord_display against a run-length reference model
module tb_coord_display;
  localparam int S = 4;
  localparam int R = 2;
  logic Clk = 1'b0, Reset = 1'b1, Freeze = 1'b0;
  logic [31:0] xCoord = '0, yCoord = '0;
  logic [7:0] an;
  logic [6:0] seg;
  logic dp, Valid;
  logic [15:0] UpdateCount;
  coord_display #(.STABLE_CYCLES(S), .REFRESH_DIV(R)) dut (
    .Clk(Clk), .Reset(Reset), .xCoord(xCoord), .yCoord(yCoord), .Freeze(Freeze),
    .an(an), .seg(seg), .dp(dp), .UpdateCount(UpdateCount), .Valid(Valid)
  );
  always #5 Clk = ~Clk;
  logic [6:0] hexTab [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                              7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                              7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                              7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
  int total = 0, bad = 0;
  logic [63:0] mLast;
  int mRun, n;
  logic [31:0] mX, mY;
  logic [15:0] mCnt;
  logic mValid, mDp, mLd;
  logic [7:0] mAn;
  logic [6:0] mSeg;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask
  // model: mRun counts consecutive edges that sampled the same pair; reset counts as one sample of 0/0
  task automatic model(input logic [31:0] x, input logic [31:0] y, input logic f, input logic r);
    logic ld;
    int idx;
    logic [31:0] ox, oy;
    logic [3:0] nib;
    if (r) begin
      mLast = '0; mRun = 1; mX = '0; mY = '0; mCnt = '0; mValid = 1'b0;
      n = 0; mAn = 8'hFE; mSeg = 7'b1000000; mDp = 1'b1; mLd = 1'b0;
    end else begin
      if ({x, y} == mLast) mRun = mRun < 1000 ? mRun + 1 : mRun;
      else begin
        mRun = 1;
        mLast = {x, y};
      end
      ld = mRun > S && !f && {x, y} != {mX, mY};
      ox = mX;
      oy = mY;
      n++;
      idx = (n / R) % 8;
      if (n % R == 0) mAn = ~(8'd1 << idx);
      if (n % R == 0 || mLd) begin
        nib = idx >= 4 ? 4'(ox >> (4 * (idx - 4))) : 4'(oy >> (4 * idx));
        mSeg = hexTab[nib];
        mDp = !(idx == 4 || (idx == 7 && ox[31:16] != 0) || (idx == 3 && oy[31:16] != 0));
      end
      if (ld) begin
        mX = x;
        mY = y;
        mCnt++;
      end
      mValid = mRun >= S && {x, y} == {mX, mY};
      mLd = ld;
    end
  endtask
  task automatic step(input logic [31:0] x, input logic [31:0] y, input logic f, input logic r);
    xCoord = x; yCoord = y; Freeze = f; Reset = r;
    @(posedge Clk);
    model(x, y, f, r);
    #1;
    chk("an", 64'(an), 64'(mAn));
    chk("seg", 64'(seg), 64'(mSeg));
    chk("dp", 64'(dp), 64'(mDp));
    chk("UpdateCount", 64'(UpdateCount), 64'(mCnt));
    chk("Valid", 64'(Valid), 64'(mValid));
  endtask
  initial begin
    logic [31:0] px [4];
    logic [31:0] py [4];
    step(0, 0, 0, 1);
    chk("reset_an", 64'(an), 64'hFE);
    chk("reset_seg", 64'(seg), 64'b1000000);
    chk("reset_cnt", 64'(UpdateCount), 64'h0);
    for (int i = 1; i <= 5; i++) begin
      step(32'h1234, 32'hAB, 0, 0);
      if (i == 4) begin
        chk("edge4_cnt", 64'(UpdateCount), 64'h0);
        chk("edge4_valid", 64'(Valid), 64'h0);
      end
    end
    chk("edge5_cnt", 64'(UpdateCount), 64'h1);
    chk("edge5_valid", 64'(Valid), 64'h1);
    for (int i = 0; i < 16; i++) begin
      step(32'h1234, 32'hAB, 0, 0);
      if (mAn == 8'hEF) begin
        chk("idx4_seg", 64'(seg), 64'b0011001);
        chk("idx4_dp", 64'(dp), 64'h0);
      end
      if (mAn == 8'hFE) chk("idx0_seg", 64'(seg), 64'b0000011);
    end
    for (int i = 0; i < 20; i++) begin
      step((i / 2) % 2 == 0 ? 32'h5 : 32'h6, 32'hAB, 0, 0);
      chk("toggle_valid", 64'(Valid), 64'h0);
    end
    chk("toggle_cnt", 64'(UpdateCount), 64'h1);
    for (int i = 0; i < 10; i++) step(32'h77, 32'hAB, 1, 0);
    chk("freeze_cnt", 64'(UpdateCount), 64'h1);
    step(32'h77, 32'hAB, 0, 0);
    chk("unfreeze_cnt", 64'(UpdateCount), 64'h2);
    for (int i = 0; i < 22; i++) begin
      step(32'h00010000, 32'hAB, 0, 0);
      if (i > 6 && mAn == 8'h7F) begin
        chk("ovf_idx7_dp", 64'(dp), 64'h0);
        chk("ovf_idx7_seg", 64'(seg), 64'b1000000);
      end
      if (i > 6 && mAn == 8'hEF) chk("ovf_idx4_seg", 64'(seg), 64'b1000000);
    end
    step(32'h00010000, 32'hAB, 0, 1);
    chk("midreset_an", 64'(an), 64'hFE);
    chk("midreset_seg", 64'(seg), 64'b1000000);
    chk("midreset_dp", 64'(dp), 64'h1);
    chk("midreset_valid", 64'(Valid), 64'h0);
    chk("midreset_cnt", 64'(UpdateCount), 64'h0);
    for (int i = 0; i < 5; i++) step(32'h1, 32'h1, 0, 0);
    chk("pre_wrap_cnt", 64'(UpdateCount), 64'h1);
    force dut.UpdateCount = 16'hFFFF;
    #1;
    release dut.UpdateCount;
    mCnt = 16'hFFFF;
    for (int i = 0; i < 5; i++) step(32'h2, 32'h2, 0, 0);
    chk("wrap_cnt", 64'(UpdateCount), 64'h0);
    px = '{32'h0, 32'hDEAD, 32'h0003FACE, 32'h9};
    py = '{32'h0, 32'hBEEF, 32'hC0D, 32'h00020001};
    for (int seg_i = 0; seg_i < 120; seg_i++) begin
      int k, len;
      logic f, r;
      k = $urandom_range(0, 3);
      len = $urandom_range(1, 8);
      f = $urandom_range(0, 3) == 0;
      for (int j = 0; j < len; j++) begin
        r = $urandom_range(0, 49) == 0;
        step(px[k], py[k], f, r);
      end
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/coord_display.md
COORD_DISPLAY -- requirements
Module: coord_display

Interface
REQ-001 The block SHALL have parameter STABLE_CYCLES, default 4: the number of consecutive cycles a coordinate pair must hold before it is displayed (minimum 2).
REQ-002 The block SHALL have parameter REFRESH_DIV, default 100000: clock cycles per digit slot (minimum 2).
REQ-003 The block SHALL have port Clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port Reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port xCoord, input, 32 bits: the X coordinate from the processor register file.
REQ-006 The block SHALL have port yCoord, input, 32 bits: the Y coordinate from the processor register file.
REQ-007 The block SHALL have port Freeze, input, 1 bit: when high, the displayed values are held.
REQ-008 The block SHALL have port an, output, 8 bits: active-low digit enables.
REQ-009 The block SHALL have port seg, output, 7 bits: active-low segments, seg[0]=a through seg[6]=g.
REQ-010 The block SHALL have port dp, output, 1 bit: active-low decimal point.
REQ-011 The block SHALL have port UpdateCount, output, 16 bits: the number of display updates.
REQ-012 The block SHALL have port Valid, output, 1 bit: the displayed pair equals the stable input pair.

Function
REQ-013 The block SHALL keep candidate registers candX and candY and a stable counter stab, saturating at STABLE_CYCLES-1.
REQ-014 Each cycle, if {xCoord,yCoord} differs from {candX,candY}, the block SHALL load the candidates with the inputs and clear stab to 0.
REQ-015 Each cycle where the inputs equal the candidates and stab < STABLE_CYCLES-1, the block SHALL increment stab.
REQ-016 The block SHALL load dispX/dispY from candX/candY when all of the following hold: inputs equal the candidates, stab == STABLE_CYCLES-1, Freeze is low, and {candX,candY} differs from {dispX,dispY}.
REQ-017 A new pair held constant SHALL therefore appear in dispX/dispY at the (STABLE_CYCLES+1)th consecutive rising edge that samples it.
REQ-018 UpdateCount SHALL increment on every dispX/dispY load and wrap from 0xFFFF to 0x0000.
REQ-019 Freeze high SHALL block only the load in REQ-016; candidate tracking and stab continue to run.
REQ-020 If the pair is stable and differs from the display when Freeze falls, the block SHALL load on the first edge that samples Freeze low.
REQ-021 Valid SHALL be registered and SHALL be 1 exactly when stab == STABLE_CYCLES-1 and {candX,candY} == {dispX,dispY}, evaluated on the same edge's next-state values.
REQ-022 A prescaler SHALL count 0..REFRESH_DIV-1; when it reaches its terminal count it SHALL wrap to 0 and advance the digit index idx, 0..7, wrapping 7 to 0.
REQ-023 Digit mapping SHALL be:
  - idx 7..4 → dispX[15:12], [11:8], [7:4], [3:0];
  - idx 3..0 → dispY[15:12], [11:8], [7:4], [3:0].
REQ-024 an, seg and dp SHALL be registered and SHALL update on the same edge idx advances, using the new idx and the current dispX/dispY.
REQ-025 an SHALL be the bitwise inverse of (1 << idx).
REQ-026 seg SHALL be the active-low hex decode of the selected nibble (g..a order), including:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010;
  - 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011;
  - C=1000110, d=0100001, E=0000110, F=0001110.
REQ-027 dp SHALL be 0 (lit) on idx 4, the X/Y separator.
REQ-028 dp SHALL be 0 on idx 7 when dispX[31:16] != 0, and on idx 3 when dispY[31:16] != 0 (overflow flags).
REQ-029 dp SHALL be 1 on all other digits.
REQ-030 Between digit advances, an, seg and dp SHALL hold their values, except that a display load SHALL refresh seg/dp for the current idx on the next edge.

Reset
REQ-031 On a Reset-high edge, including mid-operation, the block SHALL set: candX, candY, dispX, dispY, stab, prescaler, idx and UpdateCount to 0; Valid=0; an=8'hFE; seg=7'b1000000; dp=1.
REQ-032 Reset SHALL take priority over every other update on the same edge.
REQ-033 The first non-reset edge SHALL treat inputs 0/0 as already matching the candidates.

Verification (STABLE_CYCLES=4, REFRESH_DIV=2)
REQ-034 Reset, then hold x=0x1234, y=0x00AB for 5 edges: dispX=0x1234 and dispY=0x00AB on edge 5, UpdateCount=1, Valid=1 on edge 5; nothing loaded at edge 4.
REQ-035 Toggle x between 0x5 and 0x6 every 2 cycles for 20 cycles: no load, UpdateCount unchanged, Valid=0.
REQ-036 Freeze=1 while x=0x77 is held 10 cycles: display unchanged; drop Freeze: dispX=0x77 on the next edge, UpdateCount+1.
REQ-037 Free-run 16 cycles with dispX=0x1234, dispY=0x00AB: an steps FE,FD,...,7F every 2 cycles; idx4 seg=0011001 dp=0; idx0 seg=0000011.
REQ-038 x=0x00010000 stable: idx7 dp=0 and digits 7..4 show 0000; assert Reset mid-scan: all outputs equal the REQ-031 values on the next edge.
REQ-039 Force 0xFFFF updates by alternating stable pairs, then one more update: UpdateCount wraps to 0x0000.
